// File: rtl/lcd_drv_pkg.sv
// Shared state enums, HD44780 command codes and the power-on init table
// for the character-LCD driver.
package lcd_drv_pkg;

   typedef enum logic [1:0] {
      PWRWAIT,
      INIT,
      IDLE,
      REFRESH
   } top_state_t;

   typedef enum logic [2:0] {
      N_IDLE,
      N_SETUP,
      N_PULSE,
      N_HOLD,
      N_WAIT
   } nib_state_t;

   localparam logic [7:0] CMD_FUNC   = 8'h28;
   localparam logic [7:0] CMD_DISP   = 8'h0C;
   localparam logic [7:0] CMD_ENTRY  = 8'h06;
   localparam logic [7:0] CMD_CLEAR  = 8'h01;
   localparam logic [7:0] CMD_LINE0  = 8'h80;
   localparam logic [7:0] CMD_LINE1  = 8'hC0;
   localparam logic [7:0] CHAR_SPACE = 8'h20;

   localparam int INIT_STEPS = 8;
   localparam int REF_BYTES  = 34;

   typedef struct packed {
      logic [7:0] code;
      logic       nib;
      logic       clr;
   } init_step_t;

   // Single-nibble steps carry their nibble in the upper half of code.
   function automatic init_step_t init_step(input logic [5:0] idx);
      init_step_t s;
      s = '{code: CMD_CLEAR, nib: 1'b0, clr: 1'b1};
      case (idx)
         6'd0:       s = '{code: 8'h30, nib: 1'b1, clr: 1'b1};
         6'd1, 6'd2: s = '{code: 8'h30, nib: 1'b1, clr: 1'b0};
         6'd3:       s = '{code: 8'h20, nib: 1'b1, clr: 1'b0};
         6'd4:       s = '{code: CMD_FUNC, nib: 1'b0, clr: 1'b0};
         6'd5:       s = '{code: CMD_DISP, nib: 1'b0, clr: 1'b0};
         6'd6:       s = '{code: CMD_ENTRY, nib: 1'b0, clr: 1'b0};
         default:    ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// 4-bit HD44780 bus transmitter: SETUP / PULSE / HOLD per nibble, then a
// post-byte WAIT; done marks the last WAIT cycle so the next start chains.
module lcd_nibble_tx
   import lcd_drv_pkg::*;
#(
   parameter int unsigned E_PULSE_CYC = 12,
   parameter int unsigned SETUP_CYC   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  data,
   input  logic        rs,
   input  logic        nibble_only,
   input  logic [31:0] wait_cyc,
   output logic        lcd_e,
   output logic        lcd_rs,
   output logic [3:0]  lcd_db,
   output logic        done
);

   nib_state_t  st;
   logic [31:0] cnt;
   logic [31:0] wait_r;
   logic [3:0]  lo;
   logic        second;
   logic        load;

   assign done = (st == N_WAIT) && (cnt == '0);
   assign load = start && ((st == N_IDLE) || done);

   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= N_IDLE;
         cnt    <= '0;
         wait_r <= '0;
         lo     <= '0;
         second <= 1'b0;
         lcd_e  <= 1'b0;
         lcd_rs <= 1'b0;
         lcd_db <= '0;
      end else if (load) begin
         lcd_db <= data[7:4];
         lcd_rs <= rs;
         lo     <= data[3:0];
         second <= !nibble_only;
         wait_r <= wait_cyc;
         cnt    <= SETUP_CYC - 1;
         st     <= N_SETUP;
      end else begin
         unique case (st)
            N_SETUP:
               if (cnt == '0) begin
                  lcd_e <= 1'b1;
                  cnt   <= E_PULSE_CYC - 1;
                  st    <= N_PULSE;
               end else begin
                  cnt <= cnt - 1;
               end
            N_PULSE:
               if (cnt == '0) begin
                  lcd_e <= 1'b0;
                  cnt   <= SETUP_CYC - 1;
                  st    <= N_HOLD;
               end else begin
                  cnt <= cnt - 1;
               end
            N_HOLD:
               if (cnt != '0) begin
                  cnt <= cnt - 1;
               end else if (second) begin
                  // DB only moves here, with E low and a full setup ahead
                  lcd_db <= lo;
                  second <= 1'b0;
                  cnt    <= SETUP_CYC - 1;
                  st     <= N_SETUP;
               end else begin
                  cnt <= wait_r - 1;
                  st  <= N_WAIT;
               end
            N_WAIT:
               if (cnt != '0) cnt <= cnt - 1;
               else st <= N_IDLE;
            default: st <= N_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/lcd_char_driver.sv
// 2x16 shadow-buffered HD44780 driver with power-on init and frame refresh.
// Optional periodic refresh: define LCD_DRV_AUTOREFRESH_EN.
module lcd_char_driver
   import lcd_drv_pkg::*;
#(
   parameter int unsigned E_PULSE_CYC    = 12,
   parameter int unsigned SETUP_CYC      = 2,
   parameter int unsigned CMD_WAIT_CYC   = 1200,
   parameter int unsigned CLR_WAIT_CYC   = 48000,
   parameter int unsigned INIT_WAIT_CYC  = 480000,
   parameter int unsigned REFRESH_PERIOD = 24000000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       lcd_row,
   input  logic [3:0] lcd_col,
   input  logic [7:0] lcd_char,
   input  logic       lcd_we,
   input  logic       update,
   output logic       lcd_busy,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_E,
   output logic [3:0] LCD_DB
);

   top_state_t  state;
   logic [5:0]  idx;
   logic [31:0] pw_cnt;
   logic        pending;
   logic [7:0]  shadow [32];

   logic        trig;
   logic        go_ref;
   logic        start;
   logic        seq_ref;
   logic        new_frame;
   logic [5:0]  nidx;
   logic        tx_done;
   logic [7:0]  tx_data;
   logic        tx_rs;
   logic        tx_nib;
   logic [31:0] tx_wait;
   init_step_t  istep;

`ifdef LCD_DRV_AUTOREFRESH_EN
   logic [31:0] ar_cnt;
   logic        ar_run;
   logic        ar_tick;

   assign ar_run  = (state == IDLE) || (state == REFRESH);
   assign ar_tick = ar_run && (ar_cnt == REFRESH_PERIOD - 1);
   assign trig    = update | ar_tick;

   always_ff @(posedge CLK) begin
      if (RST) ar_cnt <= '0;
      else if (ar_run) ar_cnt <= ar_tick ? '0 : ar_cnt + 1;
   end
`else
   assign trig = update;
`endif

   assign LCD_RW    = 1'b0;
   assign go_ref    = pending | trig;
   assign new_frame = start && seq_ref && (nidx == 6'd0);

   // Sequencer: decides which step the transmitter loads this cycle.
   always_comb begin
      start   = 1'b0;
      seq_ref = 1'b0;
      nidx    = '0;
      unique case (state)
         PWRWAIT: start = (pw_cnt == INIT_WAIT_CYC - 1);
         INIT:
            if (tx_done) begin
               if (idx == 6'(INIT_STEPS - 1)) begin
                  start   = go_ref;
                  seq_ref = 1'b1;
               end else begin
                  start = 1'b1;
                  nidx  = idx + 6'd1;
               end
            end
         IDLE: begin
            start   = trig;
            seq_ref = 1'b1;
         end
         REFRESH:
            if (tx_done) begin
               seq_ref = 1'b1;
               if (idx == 6'(REF_BYTES - 1)) begin
                  start = go_ref;
               end else begin
                  start = 1'b1;
                  nidx  = idx + 6'd1;
               end
            end
         default: ;
      endcase
   end

   always_comb begin
      istep   = init_step(nidx);
      tx_data = istep.code;
      tx_rs   = 1'b0;
      tx_nib  = istep.nib;
      tx_wait = istep.clr ? CLR_WAIT_CYC : CMD_WAIT_CYC;
      if (seq_ref) begin
         tx_nib  = 1'b0;
         tx_wait = CMD_WAIT_CYC;
         tx_rs   = 1'b1;
         if (nidx == 6'd0) begin
            tx_data = CMD_LINE0;
            tx_rs   = 1'b0;
         end else if (nidx == 6'd17) begin
            tx_data = CMD_LINE1;
            tx_rs   = 1'b0;
         end else if (nidx < 6'd17) begin
            tx_data = shadow[5'(nidx - 6'd1)];
         end else begin
            tx_data = shadow[5'(nidx - 6'd2)];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= PWRWAIT;
         idx      <= '0;
         pw_cnt   <= '0;
         pending  <= 1'b0;
         lcd_busy <= 1'b1;
         for (int i = 0; i < 32; i++) shadow[i] <= CHAR_SPACE;
      end else begin
         if (lcd_we && !lcd_busy) shadow[{lcd_row, lcd_col}] <= lcd_char;
         if (new_frame) pending <= 1'b0;
         else if (trig && lcd_busy) pending <= 1'b1;
         if (state == PWRWAIT && !start) pw_cnt <= pw_cnt + 1;
         if (start) begin
            idx      <= nidx;
            state    <= seq_ref ? REFRESH : INIT;
            lcd_busy <= 1'b1;
         end else if ((state == INIT || state == REFRESH) && tx_done) begin
            state    <= IDLE;
            lcd_busy <= 1'b0;
         end
      end
   end

   lcd_nibble_tx #(
      .E_PULSE_CYC (E_PULSE_CYC),
      .SETUP_CYC   (SETUP_CYC)
   ) u_tx (
      .clk         (CLK),
      .rst         (RST),
      .start       (start),
      .data        (tx_data),
      .rs          (tx_rs),
      .nibble_only (tx_nib),
      .wait_cyc    (tx_wait),
      .lcd_e       (LCD_E),
      .lcd_rs      (LCD_RS),
      .lcd_db      (LCD_DB),
      .done        (tx_done)
   );

endmodule

// File: tb/tb_lcd_char_driver.sv
// Scoreboard bench for lcd_char_driver: expected bus bytes are queued by the
// stimulus and checked by a monitor that decodes nibbles on E falling edges.
module tb_lcd_char_driver;

   localparam int EP = 2;
   localparam int SC = 1;
   localparam int CW = 4;
   localparam int CL = 8;
   localparam int IW = 10;
   localparam int RP = 2000;
   localparam int NIB = 2 * SC + EP;
   localparam int BYTE_CYC = 2 * NIB + CW;
   localparam int REF_CYC = 34 * BYTE_CYC;
   localparam int INIT_CYC = IW + 4 * NIB + CL + 3 * CW + 8 * NIB + 3 * CW + CL;

   logic       CLK;
   logic       RST;
   logic       lcd_row;
   logic [3:0] lcd_col;
   logic [7:0] lcd_char;
   logic       lcd_we;
   logic       update;
   logic       lcd_busy;
   logic       LCD_RS;
   logic       LCD_RW;
   logic       LCD_E;
   logic [3:0] LCD_DB;

   lcd_char_driver #(
      .E_PULSE_CYC    (EP),
      .SETUP_CYC      (SC),
      .CMD_WAIT_CYC   (CW),
      .CLR_WAIT_CYC   (CL),
      .INIT_WAIT_CYC  (IW),
      .REFRESH_PERIOD (RP)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .lcd_row  (lcd_row),
      .lcd_col  (lcd_col),
      .lcd_char (lcd_char),
      .lcd_we   (lcd_we),
      .update   (update),
      .lcd_busy (lcd_busy),
      .LCD_RS   (LCD_RS),
      .LCD_RW   (LCD_RW),
      .LCD_E    (LCD_E),
      .LCD_DB   (LCD_DB)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       rs;
      logic       nib;
      logic [7:0] val;
   } exp_t;

   exp_t       q[$];
   logic [7:0] mb [32];
   int         vectors = 0;
   int         miscompares = 0;

   logic       mon_en = 1'b0;
   logic       e_q = 1'b0;
   logic       have_hi = 1'b0;
   logic [3:0] db_s = 4'h0;
   logic       rs_s = 1'b0;
   logic [3:0] hi = 4'h0;
   logic       rs_hi = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: DB/RS captured while E is high, nibble closed when E drops.
   always @(negedge CLK) begin
      if (!mon_en) begin
         e_q     = 1'b0;
         have_hi = 1'b0;
      end else begin
         if (LCD_E) begin
            db_s = LCD_DB;
            rs_s = LCD_RS;
         end else if (e_q) begin
            if (q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_nibble: got %0h, expected none", db_s);
            end else if (q[0].nib) begin
               chk("init_nibble", 32'({rs_s, LCD_RW, db_s}),
                   32'({q[0].rs, 1'b0, q[0].val[7:4]}));
               void'(q.pop_front());
            end else if (!have_hi) begin
               hi      = db_s;
               rs_hi   = rs_s;
               have_hi = 1'b1;
            end else begin
               chk(q[0].rs ? "data_byte" : "cmd_byte",
                   32'({rs_hi, rs_s, LCD_RW, hi, db_s}),
                   32'({q[0].rs, q[0].rs, 1'b0, q[0].val}));
               void'(q.pop_front());
               have_hi = 1'b0;
            end
         end
         e_q = LCD_E;
      end
   end

   task automatic push_init();
      q.push_back(exp_t'{rs: 1'b0, nib: 1'b1, val: 8'h30});
      q.push_back(exp_t'{rs: 1'b0, nib: 1'b1, val: 8'h30});
      q.push_back(exp_t'{rs: 1'b0, nib: 1'b1, val: 8'h30});
      q.push_back(exp_t'{rs: 1'b0, nib: 1'b1, val: 8'h20});
      q.push_back(exp_t'{rs: 1'b0, nib: 1'b0, val: 8'h28});
      q.push_back(exp_t'{rs: 1'b0, nib: 1'b0, val: 8'h0C});
      q.push_back(exp_t'{rs: 1'b0, nib: 1'b0, val: 8'h06});
      q.push_back(exp_t'{rs: 1'b0, nib: 1'b0, val: 8'h01});
   endtask

   task automatic push_frame();
      q.push_back(exp_t'{rs: 1'b0, nib: 1'b0, val: 8'h80});
      for (int i = 0; i < 16; i++)
         q.push_back(exp_t'{rs: 1'b1, nib: 1'b0, val: mb[i]});
      q.push_back(exp_t'{rs: 1'b0, nib: 1'b0, val: 8'hC0});
      for (int i = 16; i < 32; i++)
         q.push_back(exp_t'{rs: 1'b1, nib: 1'b0, val: mb[i]});
   endtask

   // Starts at the negedge where RST was just released.
   task automatic init_run(input string nm);
      int n;
      n = 0;
      while (lcd_busy && n < 5000) begin
         if (n < IW) chk("pwrwait_e_low", 32'(LCD_E), 0);
         n++;
         @(negedge CLK);
      end
      chk(nm, n, INIT_CYC);
   endtask

   task automatic wr(input logic r, input logic [3:0] c, input logic [7:0] ch);
      lcd_we = 1'b1;
      lcd_row = r;
      lcd_col = c;
      lcd_char = ch;
      @(negedge CLK);
      lcd_we = 1'b0;
   endtask

   task automatic run_refresh(input string nm, input int frames,
                              input int p1, input int p2, input int pwr);
      int n;
      update = 1'b1;
      @(negedge CLK);
      update = 1'b0;
      lcd_we = 1'b0;
      chk({nm, "_busy_t1"}, 32'(lcd_busy), 1);
      chk({nm, "_e_t1"}, 32'(LCD_E), 0);
      n = 0;
      while (lcd_busy && n < 4000) begin
         if (n == 1) chk({nm, "_e_rise_t2"}, 32'(LCD_E), 1);
         update = (n == p1) || (n == p2);
         lcd_we = (n == pwr);
         lcd_row = 1'b0;
         lcd_col = 4'd3;
         lcd_char = 8'h55;
         n++;
         @(negedge CLK);
      end
      update = 1'b0;
      lcd_we = 1'b0;
      chk({nm, "_busy_cycles"}, n, frames * REF_CYC);
      repeat (2) @(negedge CLK);
      chk({nm, "_drained"}, q.size(), 0);
   endtask

   initial begin
      int n;
      RST = 1'b1;
      update = 1'b0;
      lcd_we = 1'b0;
      lcd_row = 1'b0;
      lcd_col = 4'd0;
      lcd_char = 8'h00;
      mon_en = 1'b1;
      for (int i = 0; i < 32; i++) mb[i] = 8'h20;
      repeat (3) @(negedge CLK);
      chk("rst_busy", 32'(lcd_busy), 1);
      chk("rst_e", 32'(LCD_E), 0);
      chk("rst_db_rs_rw", 32'({LCD_DB, LCD_RS, LCD_RW}), 0);
      push_init();
      RST = 1'b0;
      init_run("init_busy_cycles");

`ifdef LCD_DRV_AUTOREFRESH_EN
      push_frame();
      push_frame();
      n = 0;
      while (!lcd_busy && n < 5000) begin
         n++;
         @(negedge CLK);
      end
      chk("auto_gap_first", n, RP);
      n = 0;
      while (lcd_busy && n < 5000) begin
         n++;
         @(negedge CLK);
      end
      chk("auto_busy_cycles", n, REF_CYC);
      n = 0;
      while (!lcd_busy && n < 5000) begin
         n++;
         @(negedge CLK);
      end
      chk("auto_gap_second", n, RP - REF_CYC);
      n = 0;
      while (lcd_busy && n < 5000) begin
         n++;
         @(negedge CLK);
      end
      repeat (2) @(negedge CLK);
      chk("auto_drained", q.size(), 0);
`else
      repeat (2) @(negedge CLK);
      chk("init_drained", q.size(), 0);

      wr(1'b0, 4'd0, 8'h41);
      wr(1'b1, 4'd15, 8'h5A);
      mb[0] = 8'h41;
      mb[31] = 8'h5A;
      push_frame();
      run_refresh("ref1", 1, -1, -1, -1);

      // write and update in the same idle cycle, then a write while busy
      lcd_we = 1'b1;
      lcd_row = 1'b0;
      lcd_col = 4'd1;
      lcd_char = 8'h42;
      mb[1] = 8'h42;
      push_frame();
      run_refresh("ref_same_cycle_wr", 1, -1, -1, 30);

      push_frame();
      run_refresh("ref_after_busy_wr", 1, -1, -1, -1);

      push_frame();
      push_frame();
      run_refresh("ref_double_update", 2, 20, 30, -1);

      push_frame();
      update = 1'b1;
      @(negedge CLK);
      update = 1'b0;
      repeat (40) @(negedge CLK);
      n = 0;
      while (!LCD_E && n < 100) begin
         n++;
         @(negedge CLK);
      end
      chk("mid_refresh_e_high", 32'(LCD_E), 1);
      mon_en = 1'b0;
      RST = 1'b1;
      @(negedge CLK);
      chk("mid_rst_e", 32'(LCD_E), 0);
      chk("mid_rst_busy", 32'(lcd_busy), 1);
      chk("mid_rst_db_rs", 32'({LCD_DB, LCD_RS}), 0);
      RST = 1'b0;
      q.delete();
      for (int i = 0; i < 32; i++) mb[i] = 8'h20;
      push_init();
      #1 mon_en = 1'b1;
      init_run("mid_rst_init_cycles");
      repeat (2) @(negedge CLK);
      chk("mid_rst_init_drained", q.size(), 0);
      push_frame();
      run_refresh("ref_after_rst", 1, -1, -1, -1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
